// File: rtl/writeback_stage_pkg.sv
// Shared opcode layout and writeback FSM encodings for the final pipeline stage.
// The optional retired-instruction counter in writeback_stage is enabled by WB_RETIRE_CNT_EN.
package writeback_stage_pkg;

  // One-hot opcode vector produced by decode and carried down the pipe
  localparam int OPCODE_WIDTH = 11;
  localparam int RTYPE        = 0;
  localparam int ITYPE        = 1;
  localparam int LOAD_WORD    = 2;
  localparam int STORE_WORD   = 3;
  localparam int BRANCH       = 4;
  localparam int JAL          = 5;
  localparam int JALR         = 6;
  localparam int LUI          = 7;
  localparam int AUIPC        = 8;
  localparam int SYSTEM       = 9;
  localparam int FENCE        = 10;

  typedef enum logic [1:0] {
    WB_RUN   = 2'd0,
    WB_STALL = 2'd1,
    WB_FLUSH = 2'd2
  } wb_state_t;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] opcode);
    return opcode[LOAD_WORD];
  endfunction

endpackage

// File: rtl/writeback_stage_fwd.sv
// Last-commit forwarding register: captures each committed write for decode bypass.
// A flush invalidates the entry so decode never forwards from a squashed path.
module wb_forward_reg #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              clr,
  output logic              valid,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      addr  <= wr_addr;
      data  <= wr_data;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the commit value, pulses the register-file write and
// tracks stall/flush status. Build with WB_RETIRE_CNT_EN for a retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wb_i_ce,
  input  logic                    wb_i_stall,
  input  logic                    wb_i_flush,
  input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  wb_i_funct3,
  input  logic [AWIDTH-1:0]       wb_i_rd_addr,
  input  logic [DWIDTH-1:0]       wb_i_rd_data,
  input  logic [DWIDTH-1:0]       wb_i_load_data,
  input  logic                    wb_i_rd_we,
  output logic                    wb_o_rf_we,
  output logic [AWIDTH-1:0]       wb_o_rf_addr,
  output logic [DWIDTH-1:0]       wb_o_rf_data,
  output logic                    wb_o_fwd_valid,
  output logic [AWIDTH-1:0]       wb_o_fwd_addr,
  output logic [DWIDTH-1:0]       wb_o_fwd_data,
  output logic                    wb_o_stall,
  output logic                    wb_o_flush,
  output logic [FUNCT_WIDTH-1:0]  wb_o_funct3,
  output logic [31:0]             wb_o_retire_cnt
);

  wb_state_t         state;
  logic              accept;
  logic              commit_we;
  logic [DWIDTH-1:0] commit_data;
  logic              unused_opcode_bits;

  // Only the load bit steers data selection; the rest of the opcode is debug context.
  assign unused_opcode_bits = &{1'b0, wb_i_opcode};

  always_comb begin
    accept      = wb_i_ce & ~wb_i_stall & ~wb_i_flush & (state == WB_RUN);
    commit_data = is_load(wb_i_opcode) ? wb_i_load_data : wb_i_rd_data;
    commit_we   = accept & wb_i_rd_we & (wb_i_rd_addr != '0);
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state        <= WB_RUN;
      wb_o_rf_we   <= 1'b0;
      wb_o_rf_addr <= '0;
      wb_o_rf_data <= '0;
      wb_o_stall   <= 1'b0;
      wb_o_flush   <= 1'b0;
      wb_o_funct3  <= '0;
    end else begin
      case (state)
        WB_RUN: begin
          if (wb_i_flush)      state <= WB_FLUSH;
          else if (wb_i_stall) state <= WB_STALL;
        end
        WB_STALL: begin
          if (wb_i_flush)       state <= WB_FLUSH;
          else if (!wb_i_stall) state <= WB_RUN;
        end
        WB_FLUSH: begin
          if (!wb_i_flush) state <= WB_RUN;
        end
        default: state <= WB_RUN;
      endcase

      wb_o_rf_we <= commit_we;
      if (commit_we) begin
        wb_o_rf_addr <= wb_i_rd_addr;
        wb_o_rf_data <= commit_data;
      end
      if (accept) wb_o_funct3 <= wb_i_funct3;

      wb_o_stall <= (wb_i_stall | (state == WB_STALL)) & ~wb_i_flush;
      wb_o_flush <= wb_i_flush;
    end
  end

  wb_forward_reg #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_fwd (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .wr      (commit_we),
    .wr_addr (wb_i_rd_addr),
    .wr_data (commit_data),
    .clr     (wb_i_flush),
    .valid   (wb_o_fwd_valid),
    .addr    (wb_o_fwd_addr),
    .data    (wb_o_fwd_data)
  );

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // Counts every accepted instruction, including stores, branches and x0 writes; wraps freely.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)      retire_cnt_q <= '0;
    else if (accept) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign wb_o_retire_cnt = retire_cnt_q;
`else
  assign wb_o_retire_cnt = '0;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. It sits directly downstream of the memory stage and consumes that stage's registered outputs (opcode, funct3, rd address, rd data, load data, rd write-enable, ce, stall, flush).
- It selects the commit value and drives a one-cycle register-file write pulse.
- It keeps a last-commit forwarding register for decode and propagates stall/flush status.
- An optional retired-instruction counter can be compiled in.

Parameters:
- DWIDTH, 32, data/register width.
- AWIDTH, 5, register address width.
- FUNCT_WIDTH, 3, funct3 width (carried for debug, not decoded).

Ports:
- wb_clk  input  1  clock, rising edge.
- wb_rst  input  1  asynchronous, active-high reset.
- wb_i_ce  input  1  upstream instruction valid.
- wb_i_stall  input  1  upstream stall.
- wb_i_flush  input  1  upstream flush.
- wb_i_opcode  input  `OPCODE_WIDTH  one-hot opcode from header.vh.
- wb_i_funct3  input  FUNCT_WIDTH  funct3.
- wb_i_rd_addr  input  AWIDTH  destination register.
- wb_i_rd_data  input  DWIDTH  ALU/jump/LUI result.
- wb_i_load_data  input  DWIDTH  aligned, extended load result.
- wb_i_rd_we  input  1  upstream write request.
- wb_o_rf_we  output  1  register-file write strobe.
- wb_o_rf_addr  output  AWIDTH  write address.
- wb_o_rf_data  output  DWIDTH  write data.
- wb_o_fwd_valid  output  1  forwarding entry valid.
- wb_o_fwd_addr  output  AWIDTH  last committed rd.
- wb_o_fwd_data  output  DWIDTH  last committed data.
- wb_o_stall  output  1  stage stalled (registered).
- wb_o_flush  output  1  stage flushing (registered).
- wb_o_funct3  output  FUNCT_WIDTH  funct3 of last accepted instruction.
- wb_o_retire_cnt  output  32  retired-instruction count.

Behaviour:
- Reset (wb_rst=1, asynchronous): every output is 0 and the FSM is in RUN.
- FSM states and transitions:
  - RUN: accept = wb_i_ce & !wb_i_stall & !wb_i_flush.
  - RUN -> STALL when wb_i_stall & !wb_i_flush.
  - Any state -> FLUSH when wb_i_flush=1 (flush has priority over stall and ce).
  - STALL -> RUN when wb_i_stall=0.
  - FLUSH -> RUN after exactly one cycle, unless wb_i_flush is still 1 (then stay in FLUSH).
  - In STALL and FLUSH, nothing is accepted.
- Commit data selection:
  - data = wb_i_opcode[`LOAD_WORD] ? wb_i_load_data : wb_i_rd_data.
  - we = wb_i_rd_we & (wb_i_rd_addr != 0), i.e. writes to x0 are dropped.
- Latency: one cycle. For an input accepted on cycle N, wb_o_rf_we/addr/data are valid on cycle N+1.
- Write strobe rules:
  - wb_o_rf_we is a single-cycle pulse per accepted instruction and is 0 on every other cycle.
  - wb_o_rf_addr/data hold their last values when no write occurs.
- Forwarding register:
  - On each committed write (we=1), fwd_addr/fwd_data are updated and fwd_valid is set.
  - FLUSH clears fwd_valid.
  - Back-to-back writes to the same rd: the newest wins.
- wb_o_stall <= (wb_i_stall | state==STALL) & !wb_i_flush.
- wb_o_flush <= wb_i_flush.
- wb_o_funct3 updates on accept only.
- Stores and branches (wb_i_rd_we=0) are accepted, counted and produce no write.
- A flush arriving in the same cycle as a valid ce discards that instruction: no write, no count.
- Reset asserted mid-operation clears any pending strobe immediately.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: a 32-bit counter increments by 1 on every accepted instruction, wraps 0xFFFFFFFF -> 0, is not cleared by flush, and drives wb_o_retire_cnt.
- Undefined: no counter flops exist and wb_o_retire_cnt is tied to 0.

Decomposition:
- OPCODE_WIDTH and the one-hot opcode bit indices (LOAD_WORD, STORE_WORD, RTYPE, ITYPE, JAL, JALR, LUI, AUIPC) come from the shared header.vh.
- Add the FSM state encodings (WB_RUN, WB_STALL, WB_FLUSH) to header.vh.
- One sub-module, wb_forward_reg, holds the forwarding register and its valid/clear logic.
- Selection logic and the FSM stay in writeback_stage.

Test Plan:
- ITYPE, rd=5, rd_data=0x1234, ce=1 -> next cycle rf_we=1, addr=5, data=0x1234; fwd_valid=1; the cycle after that rf_we=0.
- LOAD_WORD, rd=7, load_data=0xFFFFFF80, rd_data=0xDEAD -> rf_data=0xFFFFFF80.
- rd_we=1, rd=0 -> rf_we stays 0; the retire count still increments.
- ce=1 with stall=1 for 3 cycles, then stall=0 -> no write during the stall; wb_o_stall=1 for those cycles; one write after release.
- ce=1 and flush=1 in the same cycle -> no write, fwd_valid cleared, wb_o_flush=1 next cycle, FSM returns to RUN one cycle later.
- WB_RETIRE_CNT_EN defined, counter preset near wrap, then 2 accepts -> count goes 0xFFFFFFFF -> 0x00000000; with the macro undefined the count stays 0.
